// File: rtl/node_mu_search.sv
// node_mu_search: minimisation (mu-operator) node.
// Starts child f(X, Y) for Y = 0, 1, 2, ... and returns the first Y with f == 0.
//
// Handshake: toward the parent this node is a responder. A 0->1 edge on ST
// while idle starts a search. RD drops on the next edge. RD returns to 1
// together with RES/FOUND/ERR, which are valid whenever RD is 1.
// Toward the child this node is the initiator. F_ST is a one-cycle pulse
// with F_X/F_Y stable. Completion is a 0->1 edge on F_RD, and F_RES is
// valid on that edge.
module node_mu_search #(
  parameter int W = 16,
  parameter logic [W-1:0] LIMIT = 16'hFFFE,
  parameter int TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         FOUND,
  output logic         ERR,
  input  logic [W-1:0] IN0,
  output logic         F_ST,
  output logic [W-1:0] F_X,
  output logic [W-1:0] F_Y,
  input  logic         F_RD,
  input  logic [W-1:0] F_RES,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  // Watchdog counts 0 .. TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [WD-1:0] WD_LAST = WD'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          st_old;
  logic          rd_old;
  logic [WD-1:0] wdog;
  logic          wait_first;
  logic          start_det;
  logic          done_det;

  assign start_det = ST & ~st_old;
  assign done_det  = F_RD & ~rd_old;
  assign dbg_state = state;

  // Edge-detect history registers run through reset as well.
  always_ff @(posedge CLK) begin
    st_old <= ST;
    rd_old <= F_RD;
  end

  // Search sequencer: launch child, wait for its done edge, step Y or finish.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      RD         <= 1'b1;
      RES        <= '0;
      FOUND      <= 1'b0;
      ERR        <= 1'b0;
      F_ST       <= 1'b0;
      F_X        <= '0;
      F_Y        <= '0;
      wdog       <= '0;
      wait_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_det) begin
            RD    <= 1'b0;
            FOUND <= 1'b0;
            ERR   <= 1'b0;
            F_X   <= IN0;
            F_Y   <= '0;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          F_ST       <= 1'b1;
          wdog       <= '0;
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          F_ST       <= 1'b0;
          wdog       <= wdog + 1'b1;
          wait_first <= 1'b0;
          // The first WAIT cycle can see a stale rd_old, so its edge is ignored.
          if (done_det && !wait_first) begin
            if (F_RES == '0) begin
              RES   <= F_Y;
              FOUND <= 1'b1;
              RD    <= 1'b1;
              state <= S_IDLE;
            end else if (F_Y == LIMIT) begin
              RES   <= '1;
              FOUND <= 1'b0;
              RD    <= 1'b1;
              state <= S_IDLE;
            end else begin
              F_Y   <= F_Y + 1'b1;
              state <= S_LAUNCH;
            end
          end else if (WDOG_EN && wdog == WD_LAST) begin
            ERR   <= 1'b1;
            FOUND <= 1'b0;
            RES   <= '1;
            RD    <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
